// File: rtl/mips_if_id.sv
// mips_if_id: instruction-fetch and instruction-decode front end of a
// single-issue MIPS pipeline.
//
// Stages:
//   IF   - instruction memory (loaded word by word through i_we) and the PC.
//          Every PC update also loads the IF/ID register with the word at PC
//          and PC+4.
//   ID   - field decode, control decode and the 32x32 register file, which
//          bypasses a write-back happening in the same cycle. The result is
//          captured in the ID/EX register.
//
// Ports:
//   clk, i_rst          clock; asynchronous active-high reset
//   i_we, i_instr_data  load one instruction word at the write pointer
//   i_jump, i_addr2jump redirect the PC
//   i_halt              freeze fetch; ID/EX keeps decoding the held word
//   i_stall             freeze fetch and insert a bubble into ID/EX
//   i_we_wb, i_wr_addr, i_wr_data_WB   register-file write port
//   o_pcounter4, o_instruction         IF/ID register
//   o_rs .. o_reg_DB, control outputs  ID/EX register
module mips_if_id #(
    parameter int IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [31:0] i_instr_data,
    input  logic        i_jump,
    input  logic [31:0] i_addr2jump,
    input  logic        i_halt,
    input  logic        i_stall,
    input  logic        i_we_wb,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data_WB,
    output logic [31:0] o_pcounter4,
    output logic [31:0] o_instruction,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [5:0]  o_opcode,
    output logic [5:0]  o_func,
    output logic [15:0] o_addr,
    output logic [31:0] o_immediate,
    output logic [31:0] o_reg_DA,
    output logic [31:0] o_reg_DB,
    output logic        o_jump,
    output logic        o_branch,
    output logic        o_regDst,
    output logic        o_mem2Reg,
    output logic        o_memRead,
    output logic        o_memWrite,
    output logic        o_immediate_flag,
    output logic        o_regWrite,
    output logic [1:0]  o_aluSrc,
    output logic [1:0]  o_aluOp
);

    localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  opcode;
        logic [5:0]  func;
        logic [15:0] addr;
        logic [31:0] imm;
        logic [31:0] da;
        logic [31:0] db;
        logic        jump;
        logic        branch;
        logic        reg_dst;
        logic        mem2reg;
        logic        mem_read;
        logic        mem_write;
        logic        imm_flag;
        logic        reg_write;
        logic [1:0]  alu_src;
        logic [1:0]  alu_op;
    } idex_t;

    logic [31:0]   imem [IMEM_WORDS];
    logic [AW-1:0] wptr;
    logic [31:0]   pc;
    logic          pc_en;
    logic [31:0]   gpr [32];
    idex_t         dec;
    idex_t         idex_q;

    // Fetch advances only when nothing is being loaded and the pipe is not
    // frozen; a redirect requested while frozen is dropped.
    assign pc_en = ~i_we & ~i_halt & ~i_stall;

    // Instruction memory has no reset so a program survives i_rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            imem[wptr] <= i_instr_data;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wptr <= '0;
        end else if (i_we) begin
            wptr <= wptr + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            pc            <= '0;
            o_pcounter4   <= '0;
            o_instruction <= '0;
        end else if (pc_en) begin
            pc            <= i_jump ? i_addr2jump : pc + 32'd4;
            o_pcounter4   <= pc + 32'd4;
            o_instruction <= imem[pc[AW+1:2]];
        end
    end

    // Register file; entry 0 is never written so it always reads as zero.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (i_we_wb && (i_wr_addr != 5'd0)) begin
            gpr[i_wr_addr] <= i_wr_data_WB;
        end
    end

    // Decode of the IF/ID word.
    always_comb begin
        dec        = '0;
        dec.opcode = o_instruction[31:26];
        dec.rs     = o_instruction[25:21];
        dec.rt     = o_instruction[20:16];
        dec.rd     = o_instruction[15:11];
        dec.shamt  = o_instruction[10:6];
        dec.func   = o_instruction[5:0];
        dec.addr   = o_instruction[15:0];

        // Logical immediates are zero-extended, everything else sign-extended.
        if ((dec.opcode == 6'h0C) || (dec.opcode == 6'h0D) || (dec.opcode == 6'h0E)) begin
            dec.imm = {16'h0000, o_instruction[15:0]};
        end else begin
            dec.imm = {{16{o_instruction[15]}}, o_instruction[15:0]};
        end

        // Same-cycle write-back to a nonzero register is forwarded.
        if (dec.rs == 5'd0) begin
            dec.da = '0;
        end else if (i_we_wb && (i_wr_addr == dec.rs)) begin
            dec.da = i_wr_data_WB;
        end else begin
            dec.da = gpr[dec.rs];
        end

        if (dec.rt == 5'd0) begin
            dec.db = '0;
        end else if (i_we_wb && (i_wr_addr == dec.rt)) begin
            dec.db = i_wr_data_WB;
        end else begin
            dec.db = gpr[dec.rt];
        end

        case (dec.opcode)
            6'h00: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                // SLL/SRL/SRA take their shift amount from the shamt field.
                if ((dec.func == 6'h00) || (dec.func == 6'h02) || (dec.func == 6'h03)) begin
                    dec.alu_src = 2'b10;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27: begin
                dec.mem_read  = 1'b1;
                dec.mem2reg   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 2'b01;
            end
            6'h28, 6'h29, 6'h2B: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 2'b01;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec.reg_write = 1'b1;
                dec.imm_flag  = 1'b1;
                dec.alu_src   = 2'b01;
                dec.alu_op    = 2'b11;
            end
            6'h04, 6'h05: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
            end
            6'h02: begin
                dec.jump = 1'b1;
            end
            6'h03: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ID/EX: a stall or an instruction load pushes a bubble; a halt keeps
    // decoding the frozen IF/ID word.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            idex_q <= '0;
        end else if (i_stall || i_we) begin
            idex_q <= '0;
        end else begin
            idex_q <= dec;
        end
    end

    assign o_rs             = idex_q.rs;
    assign o_rt             = idex_q.rt;
    assign o_rd             = idex_q.rd;
    assign o_shamt          = idex_q.shamt;
    assign o_opcode         = idex_q.opcode;
    assign o_func           = idex_q.func;
    assign o_addr           = idex_q.addr;
    assign o_immediate      = idex_q.imm;
    assign o_reg_DA         = idex_q.da;
    assign o_reg_DB         = idex_q.db;
    assign o_jump           = idex_q.jump;
    assign o_branch         = idex_q.branch;
    assign o_regDst         = idex_q.reg_dst;
    assign o_mem2Reg        = idex_q.mem2reg;
    assign o_memRead        = idex_q.mem_read;
    assign o_memWrite       = idex_q.mem_write;
    assign o_immediate_flag = idex_q.imm_flag;
    assign o_regWrite       = idex_q.reg_write;
    assign o_aluSrc         = idex_q.alu_src;
    assign o_aluOp          = idex_q.alu_op;

endmodule

// File: tb/tb_mips_if_id.sv
// Bench for mips_if_id: reset check, the worked program sequence, a decode
// table and a long random run compared cycle by cycle against a reference
// model of the fetch/decode rules.
module tb_mips_if_id;
  localparam int IMEM_WORDS = 64;
  localparam int N_VEC = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst, i_we, i_jump, i_halt, i_stall, i_we_wb;
  logic [31:0] i_instr_data, i_addr2jump, i_wr_data_WB;
  logic [4:0]  i_wr_addr;
  logic [31:0] o_pcounter4, o_instruction, o_immediate, o_reg_DA, o_reg_DB;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_opcode, o_func;
  logic [15:0] o_addr;
  logic        o_jump, o_branch, o_regDst, o_mem2Reg, o_memRead, o_memWrite;
  logic        o_immediate_flag, o_regWrite;
  logic [1:0]  o_aluSrc, o_aluOp;

  mips_if_id #(.IMEM_WORDS(IMEM_WORDS)) dut (
    .clk(clk), .i_rst(i_rst), .i_we(i_we), .i_instr_data(i_instr_data),
    .i_jump(i_jump), .i_addr2jump(i_addr2jump), .i_halt(i_halt), .i_stall(i_stall),
    .i_we_wb(i_we_wb), .i_wr_addr(i_wr_addr), .i_wr_data_WB(i_wr_data_WB),
    .o_pcounter4(o_pcounter4), .o_instruction(o_instruction),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_opcode(o_opcode), .o_func(o_func), .o_addr(o_addr),
    .o_immediate(o_immediate), .o_reg_DA(o_reg_DA), .o_reg_DB(o_reg_DB),
    .o_jump(o_jump), .o_branch(o_branch), .o_regDst(o_regDst),
    .o_mem2Reg(o_mem2Reg), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
    .o_immediate_flag(o_immediate_flag), .o_regWrite(o_regWrite),
    .o_aluSrc(o_aluSrc), .o_aluOp(o_aluOp)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  opcode, func;
    logic [15:0] addr;
    logic [31:0] imm, da, db;
    logic        jump, branch, regdst, mem2reg, memread, memwrite, immflag, regwrite;
    logic [1:0]  alusrc, aluop;
  } ex_t;

  logic [31:0] m_imem [IMEM_WORDS];
  logic [31:0] m_gpr [32];
  int          m_wptr;
  logic [31:0] m_pc, m_if_instr, m_if_pc4;
  ex_t         m_ex;

  // Decode straight from the instruction-set rules.
  function automatic ex_t ref_decode(input logic [31:0] w);
    ex_t e;
    logic [5:0] op;
    logic [5:0] fn;
    e = '0;
    op = w[31:26];
    fn = w[5:0];
    e.opcode = op; e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[15:11];
    e.shamt = w[10:6]; e.func = fn; e.addr = w[15:0];
    if (op inside {6'h0C, 6'h0D, 6'h0E}) e.imm = {16'h0, w[15:0]};
    else e.imm = 32'($signed(w[15:0]));
    if (op == 6'h00) begin
      e.regdst = 1; e.regwrite = 1; e.aluop = 2'b10;
      e.alusrc = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b00;
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27}) begin
      e.memread = 1; e.mem2reg = 1; e.regwrite = 1; e.alusrc = 2'b01;
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      e.memwrite = 1; e.alusrc = 2'b01;
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      e.regwrite = 1; e.immflag = 1; e.alusrc = 2'b01; e.aluop = 2'b11;
    end else if (op == 6'h04 || op == 6'h05) begin
      e.branch = 1; e.aluop = 2'b01;
    end else if (op == 6'h02) begin
      e.jump = 1;
    end else if (op == 6'h03) begin
      e.jump = 1; e.regwrite = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (i_we_wb && i_wr_addr == idx) return i_wr_data_WB;
    return m_gpr[idx];
  endfunction

  task automatic model_reset();
    m_pc = 0; m_wptr = 0; m_if_instr = 0; m_if_pc4 = 0; m_ex = '0;
    for (int i = 0; i < 32; i++) m_gpr[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    ex_t nxt;
    if (i_stall || i_we) nxt = '0;
    else begin
      nxt = ref_decode(m_if_instr);
      nxt.da = rf_read(m_if_instr[25:21]);
      nxt.db = rf_read(m_if_instr[20:16]);
    end
    if (!i_we && !i_halt && !i_stall) begin
      m_if_instr = m_imem[int'((m_pc >> 2) % IMEM_WORDS)];
      m_if_pc4 = m_pc + 32'd4;
      m_pc = i_jump ? i_addr2jump : m_pc + 32'd4;
    end
    if (i_we) begin
      m_imem[m_wptr] = i_instr_data;
      m_wptr = (m_wptr + 1) % IMEM_WORDS;
    end
    if (i_we_wb && i_wr_addr != 0) m_gpr[i_wr_addr] = i_wr_data_WB;
    m_ex = nxt;
  endtask

  task automatic compare_all();
    chk("pcounter4", o_pcounter4, m_if_pc4);
    chk("instruction", o_instruction, m_if_instr);
    chk("rs", 32'(o_rs), 32'(m_ex.rs));
    chk("rt", 32'(o_rt), 32'(m_ex.rt));
    chk("rd", 32'(o_rd), 32'(m_ex.rd));
    chk("shamt", 32'(o_shamt), 32'(m_ex.shamt));
    chk("opcode", 32'(o_opcode), 32'(m_ex.opcode));
    chk("func", 32'(o_func), 32'(m_ex.func));
    chk("addr", 32'(o_addr), 32'(m_ex.addr));
    chk("immediate", o_immediate, m_ex.imm);
    chk("reg_DA", o_reg_DA, m_ex.da);
    chk("reg_DB", o_reg_DB, m_ex.db);
    chk("ctl", 32'({o_jump, o_branch, o_regDst, o_mem2Reg, o_memRead, o_memWrite,
                    o_immediate_flag, o_regWrite}),
        32'({m_ex.jump, m_ex.branch, m_ex.regdst, m_ex.mem2reg, m_ex.memread,
             m_ex.memwrite, m_ex.immflag, m_ex.regwrite}));
    chk("aluSrc", 32'(o_aluSrc), 32'(m_ex.alusrc));
    chk("aluOp", 32'(o_aluOp), 32'(m_ex.aluop));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    i_rst = 1'b0;
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    i_we = 1'b1;
    i_instr_data = w;
    cycle();
    i_we = 1'b0;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [7:0]  ctl;    // {jump,branch,regDst,mem2Reg,memRead,memWrite,imm_flag,regWrite}
    logic [1:0]  alusrc;
    logic [1:0]  aluop;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs [N_VEC];

  initial begin
    vecs[0]  = '{32'h00221821, 8'b0010_0001, 2'b00, 2'b10, 32'h00001821}; // ADDU
    vecs[1]  = '{32'h00021080, 8'b0010_0001, 2'b10, 2'b10, 32'h00001080}; // SLL
    vecs[2]  = '{32'h00021082, 8'b0010_0001, 2'b10, 2'b10, 32'h00001082}; // SRL
    vecs[3]  = '{32'h00021083, 8'b0010_0001, 2'b10, 2'b10, 32'h00001083}; // SRA
    vecs[4]  = '{32'h8C22FFFC, 8'b0001_1001, 2'b01, 2'b00, 32'hFFFFFFFC}; // LW
    vecs[5]  = '{32'h80220004, 8'b0001_1001, 2'b01, 2'b00, 32'h00000004}; // LB
    vecs[6]  = '{32'hAC228000, 8'b0000_0100, 2'b01, 2'b00, 32'hFFFF8000}; // SW
    vecs[7]  = '{32'hA0220001, 8'b0000_0100, 2'b01, 2'b00, 32'h00000001}; // SB
    vecs[8]  = '{32'h3022F000, 8'b0000_0011, 2'b01, 2'b11, 32'h0000F000}; // ANDI
    vecs[9]  = '{32'h3422FFFF, 8'b0000_0011, 2'b01, 2'b11, 32'h0000FFFF}; // ORI
    vecs[10] = '{32'h38228001, 8'b0000_0011, 2'b01, 2'b11, 32'h00008001}; // XORI
    vecs[11] = '{32'h2022FFFF, 8'b0000_0011, 2'b01, 2'b11, 32'hFFFFFFFF}; // ADDI
    vecs[12] = '{32'h28228000, 8'b0000_0011, 2'b01, 2'b11, 32'hFFFF8000}; // SLTI
    vecs[13] = '{32'h3C028000, 8'b0000_0011, 2'b01, 2'b11, 32'hFFFF8000}; // LUI
    vecs[14] = '{32'h10220003, 8'b0100_0000, 2'b00, 2'b01, 32'h00000003}; // BEQ
    vecs[15] = '{32'h1422FFFF, 8'b0100_0000, 2'b00, 2'b01, 32'hFFFFFFFF}; // BNE
    vecs[16] = '{32'h08000010, 8'b1000_0000, 2'b00, 2'b00, 32'h00000010}; // J
    vecs[17] = '{32'h0C000020, 8'b1000_0001, 2'b00, 2'b00, 32'h00000020}; // JAL
    vecs[18] = '{32'hFC00FFFF, 8'b0000_0000, 2'b00, 2'b00, 32'hFFFFFFFF}; // op 0x3F
    vecs[19] = '{32'h88228000, 8'b0000_0000, 2'b00, 2'b00, 32'hFFFF8000}; // op 0x22
    vecs[20] = '{32'h98220000, 8'b0000_0000, 2'b00, 2'b00, 32'h00000000}; // op 0x26
    vecs[21] = '{32'hA8220000, 8'b0000_0000, 2'b00, 2'b00, 32'h00000000}; // op 0x2A
  end

  // ---------------- test sequence ----------------
  initial begin
    i_rst = 1'b1; i_we = 0; i_instr_data = 0; i_jump = 0; i_addr2jump = 0;
    i_halt = 0; i_stall = 0; i_we_wb = 0; i_wr_addr = 0; i_wr_data_WB = 0;
    #3;
    model_reset();
    compare_all();                         // reset state
    i_rst = 1'b0;

    // Fill the whole memory; the write pointer wraps back to 0.
    for (int i = 0; i < IMEM_WORDS; i++) load_word($urandom());

    // Worked program, reloaded at address 0 after the wrap.
    load_word(32'h00221821);
    load_word(32'h22220004);
    load_word(32'h08000010);
    do_reset();
    cycle();
    chk("prog_first_instr", o_instruction, 32'h00221821);
    chk("prog_first_pc4", o_pcounter4, 32'd4);

    i_we_wb = 1; i_wr_addr = 5'd1; i_wr_data_WB = 32'hDEADBEEF;
    cycle();
    chk("addu_opcode", 32'(o_opcode), 32'h0);
    chk("addu_rs", 32'(o_rs), 32'd1);
    chk("addu_rt", 32'(o_rt), 32'd2);
    chk("addu_rd", 32'(o_rd), 32'd3);
    chk("addu_func", 32'(o_func), 32'h21);
    chk("addu_regdst_regwrite", 32'({o_regDst, o_regWrite}), 32'b11);
    chk("addu_aluop", 32'(o_aluOp), 32'b10);
    chk("addu_alusrc", 32'(o_aluSrc), 32'b00);
    chk("bypass_reg_DA", o_reg_DA, 32'hDEADBEEF);

    i_wr_addr = 5'd0; i_wr_data_WB = 32'h12345678;
    cycle();
    chk("addi_opcode", 32'(o_opcode), 32'h08);
    chk("addi_rs", 32'(o_rs), 32'd17);
    chk("addi_rt", 32'(o_rt), 32'd2);
    chk("addi_imm", o_immediate, 32'd4);
    chk("addi_alusrc", 32'(o_aluSrc), 32'b01);
    chk("addi_flags", 32'({o_immediate_flag, o_regWrite}), 32'b11);

    cycle();                               // J decoded, rs=0 while writing GPR0
    chk("j_jump", 32'(o_jump), 32'd1);
    chk("j_addr", 32'(o_addr), 32'h0010);
    chk("gpr0_zero", o_reg_DA, 32'd0);
    i_we_wb = 0;

    // Two stall cycles; a jump during the second one must be dropped.
    i_stall = 1;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin i_jump = 1; i_addr2jump = 32'h40; end
      cycle();
      chk("stall_hold_instr", o_instruction, m_imem[3]);
      chk("stall_hold_pc4", o_pcounter4, 32'd16);
      chk("stall_bubble_ctl", 32'({o_jump, o_branch, o_regDst, o_mem2Reg, o_memRead,
                                   o_memWrite, o_immediate_flag, o_regWrite, o_aluSrc, o_aluOp}), 32'd0);
    end
    i_stall = 0; i_jump = 1; i_addr2jump = 32'd8;
    cycle();
    i_jump = 0;
    cycle();
    chk("jump_fetch_instr", o_instruction, 32'h08000010);
    chk("jump_fetch_pc4", o_pcounter4, 32'd12);

    // Halt with a jump: fetch frozen, ID/EX keeps decoding (no bubble).
    i_halt = 1; i_jump = 1; i_addr2jump = 32'h20;
    cycle();
    chk("halt_no_bubble", 32'(o_jump), 32'd1);
    chk("halt_hold_pc4", o_pcounter4, 32'd12);
    i_halt = 0; i_jump = 0;
    cycle();
    chk("halt_jump_ignored_pc4", o_pcounter4, 32'd16);

    // Decode table: load, restart at 0, compare each word one edge after fetch.
    do_reset();
    for (int i = 0; i < N_VEC; i++) load_word(vecs[i].instr);
    do_reset();
    for (int k = 0; k <= N_VEC; k++) begin
      cycle();
      if (k > 0) begin
        chk($sformatf("vec%0d_opcode", k - 1), 32'(o_opcode), 32'(vecs[k-1].instr[31:26]));
        chk($sformatf("vec%0d_ctl", k - 1),
            32'({o_jump, o_branch, o_regDst, o_mem2Reg, o_memRead, o_memWrite,
                 o_immediate_flag, o_regWrite}), 32'(vecs[k-1].ctl));
        chk($sformatf("vec%0d_alusrc", k - 1), 32'(o_aluSrc), 32'(vecs[k-1].alusrc));
        chk($sformatf("vec%0d_aluop", k - 1), 32'(o_aluOp), 32'(vecs[k-1].aluop));
        chk($sformatf("vec%0d_imm", k - 1), o_immediate, vecs[k-1].imm);
      end
    end

    // Random run against the model.
    for (int n = 0; n < 1500; n++) begin
      i_we         = ($urandom_range(0, 9) == 0);
      i_instr_data = $urandom();
      i_halt       = ($urandom_range(0, 7) == 0);
      i_stall      = ($urandom_range(0, 7) == 0);
      i_jump       = ($urandom_range(0, 5) == 0);
      i_addr2jump  = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h0000_00FC);
      i_we_wb      = ($urandom_range(0, 1) == 1);
      i_wr_addr    = 5'($urandom_range(0, 31));
      i_wr_data_WB = $urandom();
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
